// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the 32-bit register control port: function-select
// codes (also used by the register block), command opcodes and sequencer states.
package reg_ctrl_pkg;

    localparam logic [2:0] FS_DEC   = 3'b000;
    localparam logic [2:0] FS_INC   = 3'b001;
    localparam logic [2:0] FS_LOAD  = 3'b010;
    localparam logic [2:0] FS_CLEAR = 3'b011;
    localparam logic [2:0] FS_LO8   = 3'b100;
    localparam logic [2:0] FS_LO16  = 3'b101;
    localparam logic [2:0] FS_SHL8  = 3'b110;
    localparam logic [2:0] FS_SEXT  = 3'b111;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_INC_N = 2'd2,
        OP_DEC_N = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic logic [2:0] op_funsel(input cmd_op_e op);
        logic [2:0] fs;
        fs = FS_DEC;
        case (op)
            OP_LOAD:  fs = FS_LOAD;
            OP_CLEAR: fs = FS_CLEAR;
            OP_INC_N: fs = FS_INC;
            OP_DEC_N: fs = FS_DEC;
            default:  fs = FS_DEC;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/reg_cmd_sequencer.sv
// Expands LOAD/CLEAR/INC_N/DEC_N commands into single-cycle register operations
// and tracks the value the register should hold in a shadow copy.
module reg_cmd_sequencer
    import reg_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    input  logic [7:0]  cmd_count,
    input  logic        abort,
    output logic        reg_enable,
    output logic [2:0]  reg_funSel,
    output logic [31:0] reg_i,
    output logic        done,
    output logic        aborted,
    output logic [31:0] shadow
);

    state_e      state_q, state_d;
    cmd_op_e     op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  n_q, n_d;
    logic [31:0] shadow_q, shadow_d;
    logic        abort_d;

    logic        ready_q, enable_q, done_q, aborted_q;
    logic [2:0]  funsel_q;
    logic [31:0] reg_i_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        n_d      = n_q;
        shadow_d = shadow_q;
        abort_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op_e'(cmd_op);
                    data_d  = cmd_data;
                    n_d     = (op_d == OP_LOAD || op_d == OP_CLEAR) ? 8'd1 : cmd_count;
                    state_d = (n_d != 8'd0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                // Shadow moves on the same edge the register samples its operation.
                case (op_q)
                    OP_LOAD:  shadow_d = data_q;
                    OP_CLEAR: shadow_d = 32'd0;
                    OP_INC_N: shadow_d = shadow_q + 32'd1;
                    OP_DEC_N: shadow_d = shadow_q - 32'd1;
                    default:  shadow_d = shadow_q;
                endcase
                n_d = n_q - 8'd1;
                if (abort || n_q == 8'd1) begin
                    state_d = S_DONE;
                    abort_d = abort;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            data_q    <= 32'd0;
            n_q       <= 8'd0;
            shadow_q  <= 32'd0;
            ready_q   <= 1'b1;
            enable_q  <= 1'b0;
            funsel_q  <= FS_DEC;
            reg_i_q   <= 32'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            n_q       <= n_d;
            shadow_q  <= shadow_d;
            ready_q   <= (state_d == S_IDLE);
            enable_q  <= (state_d == S_ISSUE);
            funsel_q  <= (state_d == S_ISSUE) ? op_funsel(op_d) : FS_DEC;
            reg_i_q   <= (state_d == S_ISSUE && op_d == OP_LOAD) ? data_d : 32'd0;
            done_q    <= (state_d == S_DONE);
            aborted_q <= abort_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign reg_enable = enable_q;
    assign reg_funSel = funsel_q;
    assign reg_i      = reg_i_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign shadow     = shadow_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed bench for reg_cmd_sequencer: hand-computed per-cycle expectations
// relative to the accept edge k (sample j = cycle k+j, taken on the falling edge).
module tb_reg_cmd_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [7:0]  cmd_count = 8'd0;
    logic        abort = 1'b0;
    logic        reg_enable;
    logic [2:0]  reg_funSel;
    logic [31:0] reg_i;
    logic        done;
    logic        aborted;
    logic [31:0] shadow;

    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    reg_cmd_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_count(cmd_count), .abort(abort),
        .reg_enable(reg_enable), .reg_funSel(reg_funSel), .reg_i(reg_i),
        .done(done), .aborted(aborted), .shadow(shadow)
    );

    task automatic test_reset();
        @(negedge clock);
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
        vecs++; if (reg_enable !== 1'b0) begin errs++; $display("FAIL rst_enable got %b exp 0", reg_enable); end
        vecs++; if (reg_funSel !== 3'b000) begin errs++; $display("FAIL rst_funsel got %b exp 000", reg_funSel); end
        vecs++; if (reg_i !== 32'd0) begin errs++; $display("FAIL rst_reg_i got %h exp 0", reg_i); end
        vecs++; if (done !== 1'b0 || aborted !== 1'b0) begin errs++; $display("FAIL rst_done got %b/%b exp 0/0", done, aborted); end
        vecs++; if (shadow !== 32'd0) begin errs++; $display("FAIL rst_shadow got %h exp 0", shadow); end
        reset_n = 1'b1;
    endtask

    // Applies one command, observes cycles k+1..k+n+2, checks the full per-cycle trace.
    task automatic test_cmd(input string nm, input logic [1:0] op, input logic [31:0] d,
                            input logic [7:0] cnt, input int n, input logic [2:0] fs,
                            input logic [31:0] exp_shadow);
        logic        e_en, e_done, e_rdy;
        logic [31:0] e_ri;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = cnt;
        @(posedge clock);
        for (int j = 1; j <= n + 2; j++) begin
            @(negedge clock);
            if (j == 1) begin
                // Scramble fields after accept: the command in flight must not see them.
                cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~d; cmd_count = cnt + 8'd7;
            end
            e_en   = (j <= n);
            e_done = (j == n + 1);
            e_rdy  = (j >= n + 2);
            e_ri   = (e_en && op == 2'd0) ? d : 32'd0;
            vecs++; if (reg_enable !== e_en) begin errs++; $display("FAIL %s_en j=%0d got %b exp %b", nm, j, reg_enable, e_en); end
            vecs++; if (reg_funSel !== (e_en ? fs : 3'b000)) begin errs++; $display("FAIL %s_funsel j=%0d got %b exp %b", nm, j, reg_funSel, e_en ? fs : 3'b000); end
            vecs++; if (reg_i !== e_ri) begin errs++; $display("FAIL %s_reg_i j=%0d got %h exp %h", nm, j, reg_i, e_ri); end
            vecs++; if (done !== e_done || aborted !== 1'b0) begin errs++; $display("FAIL %s_done j=%0d got %b/%b exp %b/0", nm, j, done, aborted, e_done); end
            vecs++; if (cmd_ready !== e_rdy) begin errs++; $display("FAIL %s_ready j=%0d got %b exp %b", nm, j, cmd_ready, e_rdy); end
        end
        vecs++; if (shadow !== exp_shadow) begin errs++; $display("FAIL %s_shadow got %h exp %h", nm, shadow, exp_shadow); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  e_fs;
        logic [31:0] e_ri;
        logic        e_en, e_done, e_rdy;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 32'hAAAA_AAAA; cmd_count = 8'd0;
        @(posedge clock);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clock);
            if (j == 1) cmd_op = 2'd1;       // CLEAR queued with valid still high
            if (j == 4) cmd_valid = 1'b0;
            e_en   = (j == 1 || j == 4);
            e_done = (j == 2 || j == 5);
            e_rdy  = (j == 3 || j == 6);
            e_fs   = 2'd0;
            e_ri   = (j == 1) ? 32'hAAAA_AAAA : 32'd0;
            vecs++; if (reg_enable !== e_en) begin errs++; $display("FAIL b2b_en j=%0d got %b exp %b", j, reg_enable, e_en); end
            vecs++; if (reg_funSel !== (j == 1 ? 3'b010 : j == 4 ? 3'b011 : 3'b000)) begin errs++; $display("FAIL b2b_funsel j=%0d got %b", j, reg_funSel); end
            vecs++; if (reg_i !== e_ri) begin errs++; $display("FAIL b2b_reg_i j=%0d got %h exp %h", j, reg_i, e_ri); end
            vecs++; if (done !== e_done) begin errs++; $display("FAIL b2b_done j=%0d got %b exp %b", j, done, e_done); end
            vecs++; if (cmd_ready !== e_rdy) begin errs++; $display("FAIL b2b_ready j=%0d got %b exp %b", j, cmd_ready, e_rdy); end
            if (j == 2) begin
                vecs++; if (shadow !== 32'hAAAA_AAAA) begin errs++; $display("FAIL b2b_shadow_load got %h exp aaaaaaaa", shadow); end
            end
            if (e_fs != 2'd0) e_fs = 2'd0;
        end
        vecs++; if (shadow !== 32'd0) begin errs++; $display("FAIL b2b_shadow_clear got %h exp 0", shadow); end
    endtask

    task automatic test_abort();
        // From shadow 0: DEC_N 10 cut short in its 4th issue cycle.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_count = 8'd10; cmd_data = 32'd0;
        @(posedge clock);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            abort = 1'b0;
            vecs++; if (reg_enable !== (j <= 4)) begin errs++; $display("FAIL abort_en j=%0d got %b exp %b", j, reg_enable, j <= 4); end
            vecs++; if (done !== (j == 5) || aborted !== (j == 5)) begin errs++; $display("FAIL abort_done j=%0d got %b/%b exp %b/%b", j, done, aborted, j == 5, j == 5); end
            vecs++; if (cmd_ready !== (j == 6)) begin errs++; $display("FAIL abort_ready j=%0d got %b exp %b", j, cmd_ready, j == 6); end
            if (j == 4) abort = 1'b1;
            if (j == 6) abort = 1'b1;        // abort in IDLE must be ignored
        end
        vecs++; if (shadow !== 32'hFFFF_FFFC) begin errs++; $display("FAIL abort_shadow got %h exp fffffffc", shadow); end
        @(negedge clock);
        abort = 1'b0;
        vecs++; if (cmd_ready !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin errs++; $display("FAIL abort_idle got rdy=%b done=%b ab=%b exp 1/0/0", cmd_ready, done, aborted); end
    endtask

    task automatic test_reset_mid_issue();
        int ndone = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 8'd5;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        vecs++; if (reg_enable !== 1'b1) begin errs++; $display("FAIL rmid_pre_en got %b exp 1", reg_enable); end
        #2 reset_n = 1'b0;
        #1;
        vecs++; if (reg_enable !== 1'b0) begin errs++; $display("FAIL rmid_en got %b exp 0", reg_enable); end
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b exp 1", cmd_ready); end
        vecs++; if (shadow !== 32'd0) begin errs++; $display("FAIL rmid_shadow got %h exp 0", shadow); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clock);
            if (done !== 1'b0 || reg_enable !== 1'b0) ndone++;
        end
        vecs++; if (ndone != 0) begin errs++; $display("FAIL rmid_no_done got %0d active cycles exp 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_cmd("load", 2'd0, 32'h1234_0000, 8'd0, 1, 3'b010, 32'h1234_0000);
        test_cmd("preload", 2'd0, 32'hFFFF_FFFE, 8'd9, 1, 3'b010, 32'hFFFF_FFFE);
        test_cmd("inc3", 2'd2, 32'h5555_0000, 8'd3, 3, 3'b001, 32'h0000_0001);
        test_cmd("dec0", 2'd3, 32'h0, 8'd0, 0, 3'b000, 32'h0000_0001);
        test_cmd("dec2", 2'd3, 32'h0, 8'd2, 2, 3'b000, 32'hFFFF_FFFF);
        test_back_to_back();
        test_abort();
        test_reset_mid_issue();
        test_cmd("recover", 2'd0, 32'h0BAD_F00D, 8'd0, 1, 3'b010, 32'h0BAD_F00D);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
